// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blank and frame strobes.
// All registered outputs are computed from the next counter values so they line up with DrawX/DrawY.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_FRONT_START = 10'(H_VISIBLE);
   localparam logic [9:0] H_SYNC_START  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_BACK_START  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_FRONT_START = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYNC_START  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_BACK_START  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   logic [9:0] hc_r, vc_r, hc_nxt_s, vc_nxt_s;
   phase_t     h_state_r, v_state_r, h_state_nxt_s, v_state_nxt_s;
   logic       hs_r, vs_r, blank_r, line_start_r, frame_start_r;
   logic [7:0] frame_count_r;

   // Next raster position: column wraps every line, row advances only on the column wrap.
   always_comb begin
      hc_nxt_s = hc_r;
      vc_nxt_s = vc_r;
      if (hc_r == H_LAST) begin
         hc_nxt_s = 10'd0;
         if (vc_r == V_LAST) begin
            vc_nxt_s = 10'd0;
         end else begin
            vc_nxt_s = vc_r + 10'd1;
         end
      end else begin
         hc_nxt_s = hc_r + 10'd1;
         vc_nxt_s = vc_r;
      end
   end

   // Phase transitions fire when the next counter value crosses a phase boundary.
   always_comb begin
      h_state_nxt_s = h_state_r;
      v_state_nxt_s = v_state_r;
      case (h_state_r)
         PH_ACTIVE: if (hc_nxt_s == H_FRONT_START) h_state_nxt_s = PH_FRONT;  else h_state_nxt_s = PH_ACTIVE;
         PH_FRONT:  if (hc_nxt_s == H_SYNC_START)  h_state_nxt_s = PH_SYNC;   else h_state_nxt_s = PH_FRONT;
         PH_SYNC:   if (hc_nxt_s == H_BACK_START)  h_state_nxt_s = PH_BACK;   else h_state_nxt_s = PH_SYNC;
         PH_BACK:   if (hc_nxt_s == 10'd0)         h_state_nxt_s = PH_ACTIVE; else h_state_nxt_s = PH_BACK;
         default:   h_state_nxt_s = PH_BACK;
      endcase
      case (v_state_r)
         PH_ACTIVE: if (vc_nxt_s == V_FRONT_START) v_state_nxt_s = PH_FRONT;  else v_state_nxt_s = PH_ACTIVE;
         PH_FRONT:  if (vc_nxt_s == V_SYNC_START)  v_state_nxt_s = PH_SYNC;   else v_state_nxt_s = PH_FRONT;
         PH_SYNC:   if (vc_nxt_s == V_BACK_START)  v_state_nxt_s = PH_BACK;   else v_state_nxt_s = PH_SYNC;
         PH_BACK:   if (vc_nxt_s == 10'd0)         v_state_nxt_s = PH_ACTIVE; else v_state_nxt_s = PH_BACK;
         default:   v_state_nxt_s = PH_BACK;
      endcase
   end

   // Counter and phase state registers; reset parks everything on the last pixel of the frame.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc_r      <= H_LAST;
         vc_r      <= V_LAST;
         h_state_r <= PH_BACK;
         v_state_r <= PH_BACK;
      end else begin
         hc_r      <= hc_nxt_s;
         vc_r      <= vc_nxt_s;
         h_state_r <= h_state_nxt_s;
         v_state_r <= v_state_nxt_s;
      end
   end

   // Registered outputs derived from next-cycle phase so they match the pixel shown on DrawX/DrawY.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hs_r          <= 1'b1;
         vs_r          <= 1'b1;
         blank_r       <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_count_r <= 8'hFF;
      end else begin
         hs_r          <= (h_state_nxt_s != PH_SYNC);
         vs_r          <= (v_state_nxt_s != PH_SYNC);
         blank_r       <= (h_state_nxt_s == PH_ACTIVE) && (v_state_nxt_s == PH_ACTIVE);
         line_start_r  <= (hc_nxt_s == 10'd0);
         frame_start_r <= (hc_nxt_s == 10'd0) && (vc_nxt_s == 10'd0);
         if ((hc_nxt_s == 10'd0) && (vc_nxt_s == 10'd0)) begin
            frame_count_r <= frame_count_r + 8'd1;
         end else begin
            frame_count_r <= frame_count_r;
         end
      end
   end

   assign DrawX       = hc_r;
   assign DrawY       = vc_r;
   assign hs          = hs_r;
   assign vs          = vs_r;
   assign blank       = blank_r;
   assign line_start  = line_start_r;
   assign frame_start = frame_start_r;
   assign frame_count = frame_count_r;

endmodule
